// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// MacSequencer (module mac_sequencer)
//
// Purpose:
//   Sequences a matrix-vector product y = M * v through an external
//   multiply-accumulate unit. For each row i it streams the matrix row and
//   the vector out of two read-latency-1 memories. It hands each operand pair
//   to the MAC, then captures the accumulator as the row result and clears
//   the MAC for the next row.
//
//   Per row the schedule is:
//     ISSUE (n_eff cycles) -> DRAIN (1 cycle) -> STORE (1 cycle)
//   A run ends with one FINISH cycle, which carries the done pulse.
//
// Parameters:
//   DATA_WIDTH - width of operands, accumulator and results.
//   MAX_N      - largest supported dimension (power of two).
//
// Ports:
//   clk        - clock; all logic runs on its rising edge.
//   rst        - synchronous, active-low reset.
//   start      - one-cycle run request; ignored while busy.
//   n          - requested dimension; sampled on an accepted start.
//                Values above MAX_N are clamped to MAX_N.
//   mat_addr   - matrix word address {i, j}.
//   vec_addr   - vector word address j.
//   rd_en      - read strobe; data returns on the next cycle.
//   mat_rdata  - matrix read data.
//   vec_rdata  - vector read data.
//   A, B       - MAC operands, valid while enable is high.
//   enable     - MAC accumulate strobe (rd_en delayed by one cycle).
//   retro      - MAC clear strobe, asserted in the row-store cycle.
//   acc_out    - MAC accumulator value.
//   res_valid  - row result strobe.
//   res_data   - row result (acc_out passed through unmodified).
//   res_idx    - row index of res_data.
//   busy       - high whenever the sequencer is not idle.
//   done       - one-cycle pulse at the end of a run.
// ---------------------------------------------------------------------------
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_N      = 8,
    localparam int AW        = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW:0]           n,
    output logic [2*AW-1:0]       mat_addr,
    output logic [AW-1:0]         vec_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] mat_rdata,
    input  logic [DATA_WIDTH-1:0] vec_rdata,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  enable,
    output logic                  retro,
    input  logic [DATA_WIDTH-1:0] acc_out,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [AW-1:0]         res_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        STORE,
        FINISH
    } state_t;

    localparam logic [AW:0]   MAX_N_L = (AW+1)'(MAX_N);
    localparam logic [AW:0]   N_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    state_t                state_q;
    logic [AW-1:0]         i_q;
    logic [AW-1:0]         j_q;
    logic [AW:0]           neff_q;
    logic                  rd_en_q;
    logic [2*AW-1:0]       mat_addr_q;
    logic [AW-1:0]         vec_addr_q;
    logic                  enable_q;
    logic                  retro_q;
    logic                  res_valid_q;
    logic [AW-1:0]         res_idx_q;
    logic                  done_q;

    logic [AW:0]           neff_d;
    logic [AW-1:0]         i_d;
    logic [AW-1:0]         j_d;
    logic                  last_col;
    logic                  last_row;

    // Next-value helpers for the FSM.
    // neff_d clamps the requested dimension so that indices always fit
    // in AW bits. last_col and last_row mark the final column of the
    // current row and the final row of the run, respectively.
    always_comb begin
        neff_d   = (n > MAX_N_L) ? MAX_N_L : n;
        i_d      = i_q + IDX_ONE;
        j_d      = j_q + IDX_ONE;
        last_col = ({1'b0, j_q} == (neff_q - N_ONE));
        last_row = ({1'b0, i_q} == (neff_q - N_ONE));
    end

    // Sequencer FSM.
    // Every output is registered. It is set on the transition into the
    // state that presents it, so it is valid for the whole of that state.
    // enable is simply rd_en delayed one stage, which lines it up with the
    // read data that returns one cycle after the address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            neff_q      <= '0;
            rd_en_q     <= 1'b0;
            mat_addr_q  <= '0;
            vec_addr_q  <= '0;
            enable_q    <= 1'b0;
            retro_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            enable_q    <= rd_en_q;
            retro_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        neff_q <= neff_d;
                        i_q    <= '0;
                        j_q    <= '0;
                        if (neff_d == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ISSUE;
                            rd_en_q    <= 1'b1;
                            mat_addr_q <= '0;
                            vec_addr_q <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (last_col) begin
                        state_q    <= DRAIN;
                        j_q        <= '0;
                        rd_en_q    <= 1'b0;
                        mat_addr_q <= '0;
                        vec_addr_q <= '0;
                    end else begin
                        j_q        <= j_d;
                        mat_addr_q <= {i_q, j_d};
                        vec_addr_q <= j_d;
                    end
                end

                // The last read of the row is being accumulated in this
                // cycle, so the result can only be captured one cycle later.
                DRAIN: begin
                    state_q     <= STORE;
                    retro_q     <= 1'b1;
                    res_valid_q <= 1'b1;
                    res_idx_q   <= i_q;
                end

                STORE: begin
                    if (last_row) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ISSUE;
                        i_q        <= i_d;
                        rd_en_q    <= 1'b1;
                        mat_addr_q <= {i_d, {AW{1'b0}}};
                        vec_addr_q <= '0;
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operands and result are pass-throughs from the memories and the MAC.
    // They are gated by their strobes so that every output reads zero
    // while idle and after reset.
    always_comb begin
        A        = enable_q    ? mat_rdata : '0;
        B        = enable_q    ? vec_rdata : '0;
        res_data = res_valid_q ? acc_out   : '0;
    end

    assign mat_addr  = mat_addr_q;
    assign vec_addr  = vec_addr_q;
    assign rd_en     = rd_en_q;
    assign enable    = enable_q;
    assign retro     = retro_q;
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

    // Clearing and accumulating in the same cycle would corrupt a row.
    noClearDuringAccumulate: assert property (
        @(posedge clk) disable iff (!rst) !(retro_q && enable_q)
    );

endmodule

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer
//
// Purpose:
//   Self-checking bench for mac_sequencer. It surrounds the DUT with three
//   behavioural models:
//     - two read-latency-1 memories (matrix and vector);
//     - a MAC accumulator.
//   Expected per-cycle behaviour comes from the run schedule:
//     - each row lasts n_eff+2 cycles;
//     - a run lasts n_eff*(n_eff+2)+1 cycles.
//   Expected row results are computed as plain integer dot products.
// ---------------------------------------------------------------------------
module tb_mac_sequencer;

    localparam int DW   = 8;
    localparam int MAXN = 8;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [AW:0]     n = '0;
    logic [2*AW-1:0] mat_addr;
    logic [AW-1:0]   vec_addr;
    logic            rd_en;
    logic [DW-1:0]   mat_rdata = '0;
    logic [DW-1:0]   vec_rdata = '0;
    logic [DW-1:0]   A;
    logic [DW-1:0]   B;
    logic            enable;
    logic            retro;
    logic [DW-1:0]   acc_out;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [AW-1:0]   res_idx;
    logic            busy;
    logic            done;

    logic [DW-1:0]   memM [0:MAXN*MAXN-1];
    logic [DW-1:0]   memV [0:MAXN-1];
    logic [DW-1:0]   acc = '0;
    logic [2*DW-1:0] prod;

    int checks = 0;
    int passes = 0;

    mac_sequencer #(.DATA_WIDTH(DW), .MAX_N(MAXN)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .mat_addr(mat_addr), .vec_addr(vec_addr), .rd_en(rd_en),
        .mat_rdata(mat_rdata), .vec_rdata(vec_rdata),
        .A(A), .B(B), .enable(enable), .retro(retro), .acc_out(acc_out),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            mat_rdata <= memM[mat_addr];
            vec_rdata <= memV[vec_addr];
        end
    end

    // MAC accumulator model. It shares the system reset, so an aborted run
    // leaves no stale partial sum behind.
    assign prod    = A * B;
    assign acc_out = acc;
    always @(posedge clk) begin
        if (!rst)        acc <= '0;
        else if (retro)  acc <= '0;
        else if (enable) acc <= acc + prod[DW-1:0];
    end

    function automatic logic [DW-1:0] rowSum(input int row, input int ne);
        int s = 0;
        for (int j = 0; j < ne; j++)
            s += int'(memM[row*MAXN+j]) * int'(memV[j]);
        return DW'(s);
    endfunction

    task automatic fillRandom();
        for (int k = 0; k < MAXN*MAXN; k++) memM[k] = DW'($urandom);
        for (int k = 0; k < MAXN; k++)      memV[k] = DW'($urandom);
    endtask

    // Runs one job:
    //   - start is pulsed in cycle 0;
    //   - a second start is pulsed in restartCycle (0 = none);
    //   - rst is pulled low in abortCycle (0 = none).
    // Every output is checked in every cycle through two idle cycles
    // after the run.
    task automatic runJob(input int nreq, input int restartCycle, input int abortCycle);
        int ne, total, row, pos;
        logic expRd, expEn, expStore, expBusy, expDone;
        logic [2*AW-1:0] expMaddr;
        logic [AW-1:0]   expVaddr;
        ne    = (nreq > MAXN) ? MAXN : nreq;
        total = ne * (ne + 2) + 1;
        @(posedge clk); #1;
        start = 1'b1;
        n     = (AW+1)'(nreq);
        for (int c = 1; c <= total + 2; c++) begin
            @(posedge clk); #1;
            start = (c == restartCycle);
            n     = (AW+1)'($urandom_range(0, 15));
            rst   = (c == abortCycle) ? 1'b0 : 1'b1;
            @(negedge clk);
            expRd = 0; expEn = 0; expStore = 0; expBusy = 0; expDone = 0;
            expMaddr = '0; expVaddr = '0; row = 0; pos = 0;
            if (abortCycle > 0 && c > abortCycle) begin
                expBusy = 0;
            end else if (c < total) begin
                row      = (c - 1) / (ne + 2);
                pos      = (c - 1) % (ne + 2);
                expBusy  = 1;
                expRd    = (pos < ne);
                expEn    = (pos >= 1) && (pos <= ne);
                expStore = (pos == ne + 1);
                if (expRd) begin
                    expMaddr = (2*AW)'(row * MAXN + pos);
                    expVaddr = AW'(pos);
                end
            end else if (c == total) begin
                expBusy = 1;
                expDone = 1;
            end
            checks++;
            if ({rd_en, enable, retro, res_valid, busy, done} !==
                {expRd, expEn, expStore, expStore, expBusy, expDone}) begin
                $display("[TB] FAIL ctrl n=%0d cycle %0d: got rd/en/retro/val/busy/done=%b required %b",
                         nreq, c, {rd_en, enable, retro, res_valid, busy, done},
                         {expRd, expEn, expStore, expStore, expBusy, expDone});
            end else passes++;
            checks++;
            if ({mat_addr, vec_addr} !== {expMaddr, expVaddr}) begin
                $display("[TB] FAIL addr n=%0d cycle %0d: got mat=%0d vec=%0d required mat=%0d vec=%0d",
                         nreq, c, mat_addr, vec_addr, expMaddr, expVaddr);
            end else passes++;
            if (expEn) begin
                checks++;
                if (A !== memM[row*MAXN+pos-1] || B !== memV[pos-1]) begin
                    $display("[TB] FAIL operands n=%0d cycle %0d: got A=%0d B=%0d required A=%0d B=%0d",
                             nreq, c, A, B, memM[row*MAXN+pos-1], memV[pos-1]);
                end else passes++;
            end
            if (expStore) begin
                checks++;
                if (res_idx !== AW'(row) || res_data !== rowSum(row, ne)) begin
                    $display("[TB] FAIL result n=%0d cycle %0d: got idx=%0d data=%0d required idx=%0d data=%0d",
                             nreq, c, res_idx, res_data, row, rowSum(row, ne));
                end else passes++;
            end
            if (abortCycle > 0 && c > abortCycle) begin
                checks++;
                if ({A, B, res_data, res_idx} !== '0) begin
                    $display("[TB] FAIL abortZero cycle %0d: got A=%0d B=%0d data=%0d idx=%0d required all 0",
                             c, A, B, res_data, res_idx);
                end else passes++;
            end
        end
        start = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst   = 1'b0;
        start = 1'b1;
        n     = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rd_en, enable, retro, res_valid, busy, done, mat_addr, vec_addr, A, B, res_data, res_idx} !== '0) begin
                $display("[TB] FAIL reset: got rd=%b en=%b busy=%b done=%b val=%b required all outputs 0",
                         rd_en, enable, busy, done, res_valid);
            end else passes++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL resetIdle: got busy=%b required 0", busy);
        else passes++;
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        fillRandom();
        memM[0] = 1; memM[1] = 2; memM[8] = 3; memM[9] = 4;
        memV[0] = 5; memV[1] = 6;
        runJob(2, 0, 0);
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        fillRandom();
        memM[0] = 7; memV[0] = 3;
        runJob(1, 0, 0);
    endtask

    task automatic test_zero();
        $display("[TB] test_zero");
        runJob(0, 0, 0);
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        fillRandom();
        memM[0] = 200; memM[1] = 100;
        memV[0] = 2;   memV[1] = 1;
        runJob(2, 0, 0);
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        fillRandom();
        memM[0] = 1; memM[1] = 2; memM[8] = 3; memM[9] = 4;
        memV[0] = 5; memV[1] = 6;
        runJob(2, 3, 0);
        runJob(3, 0, 0);
    endtask

    task automatic test_reset_midrun();
        $display("[TB] test_reset_midrun");
        fillRandom();
        memM[0] = 1; memM[1] = 2; memM[8] = 3; memM[9] = 4;
        memV[0] = 5; memV[1] = 6;
        runJob(2, 6, 0);
        runJob(2, 0, 6);
        runJob(2, 0, 0);
    endtask

    task automatic test_random();
        int nr, ne, total, rs;
        $display("[TB] test_random");
        for (int t = 0; t < 8; t++) begin
            fillRandom();
            nr    = (t == 0) ? 12 : int'($urandom_range(0, 15));
            ne    = (nr > MAXN) ? MAXN : nr;
            total = ne * (ne + 2) + 1;
            rs    = (total > 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, total - 1)) : 0;
            runJob(nr, rs, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_zero();
        test_wrap();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
